wdt_multi: RTL and testbench
============================

Name: wdt_multi

Overview:
- Multi-channel watchdog timer with NUM_CH independent channels.
- Each channel has its own timeout and an optional early-kick window.
- All channels share one programmable prescaler.
- Single-clock successor of the single-channel WDT; any CDC on en/kick is done outside this block. wto/irq feed the reset/interrupt controller.

Parameters:
- NUM_CH, 4, number of watchdog channels (1..16).
- CNT_W, 32, width of the per-channel down-counter, timeout and window registers.
- PRE_W, 8, width of the shared prescaler.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- prescale  in  PRE_W  tick divider; a tick occurs every prescale+1 cycles. Must be static while any channel is running.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  max(1,$clog2(NUM_CH))  channel selected for cfg write and for readback.
- cfg_timeout  in  CNT_W  timeout reload value.
- cfg_window  in  CNT_W  early-kick window; 0 disables window mode.
- en  in  NUM_CH  per-channel enable, level.
- kick  in  NUM_CH  per-channel kick (WDLIVE), one-cycle pulse.
- wto  out  NUM_CH  per-channel timeout/violation flag, sticky.
- early  out  NUM_CH  the channel expired because of an early kick.
- irq  out  1  OR of wto.
- rd_cnt  out  CNT_W  current counter of channel cfg_ch (0 if cfg_ch >= NUM_CH).

Behaviour:
- Reset:
  - All state, counters, timeout/window registers and the prescaler clear to 0.
  - wto, early and irq are 0; every channel is in IDLE.
- Prescaler:
  - Free-running pre_cnt; tick=1 in a cycle where pre_cnt==prescale, and pre_cnt then returns to 0.
  - prescale=0 gives a tick every cycle.
  - The prescaler is never restarted by channel events.
- Config:
  - cfg_we with cfg_ch < NUM_CH writes timeout_reg[cfg_ch] and window_reg[cfg_ch] at the clock edge.
  - cfg_ch >= NUM_CH: write ignored.
  - A new value takes effect on the next reload; it does not disturb a running count.
- Channel FSM, per channel i (states IDLE, RUN, EXPIRED):
  - IDLE: cnt holds. en[i]=1 -> RUN, cnt <= timeout_reg[i].
  - RUN, priority order:
    1. en[i]=0 -> IDLE.
    2. kick[i]=1:
       - if window_reg[i]!=0 and cnt > window_reg[i] -> EXPIRED with early[i] <= 1 (kick too soon);
       - otherwise cnt <= timeout_reg[i] and the channel stays in RUN.
    3. tick with cnt==0 -> EXPIRED.
    4. tick -> cnt <= cnt-1.
  - EXPIRED: cnt holds. kick is ignored. en[i]=0 -> IDLE, which clears wto[i] and early[i] at that edge.
  - Two-bit state encoding; unused codes recover to IDLE.
- Outputs:
  - wto[i] = (state==EXPIRED), taken straight from the state register with no extra flop.
  - irq = |wto, combinational from registers.
- Latency: with T=timeout, P=prescale and no kicks, wto rises on the (T+1)-th tick after the edge that samples en (T+2 edges when P=0).
- Boundaries:
  - Kick in the same cycle as a cnt==0 tick: kick wins (reload or early violation); no timeout.
  - Kick with cnt == window_reg is legal.
  - T=0: expires on the first tick after enable.
  - en and kick in the same cycle from IDLE: enable only; the kick is ignored.
  - en deasserted in the same cycle as expiry: go to IDLE.
  - Channels are fully independent; simultaneous events on several channels are handled in parallel.
  - No counter underflow: cnt never wraps below 0.

Test Plan:
- P=0, ch0 T=3, window 0, en[0]=1 at edge 0, no kicks -> cnt 3,2,1,0; wto[0]=1 and irq=1 after edge 4; other channels stay 0.
- P=3, ch1 T=2 -> wto[1] rises on the 3rd tick after enable (about 12 cycles, depending on prescaler phase). Re-check exact timing against the counted pre_cnt.
- ch0 T=10, window 4; kick when cnt=7 -> EXPIRED next edge, wto[0]=1, early[0]=1. Repeat with kick at cnt=4 -> cnt reloads to 10, no wto.
- Kick coinciding with cnt==0 tick (window 0) -> cnt reloads to T, wto stays 0.
- Expired ch2, en[2] held 1 -> wto sticky and kicks ignored. en[2]=0 -> wto[2] and early[2] clear at the next edge. Re-enable -> counts from the new timeout_reg written during EXPIRED.
- Assert rst mid-count on all channels -> all outputs 0 immediately. Write with cfg_ch=NUM_CH -> no register changes, rd_cnt=0.

Source files
------------

// File: rtl/wdt_multi.sv
// Multi-channel watchdog: per-channel timeout and early-kick window,
// one shared free-running prescaler.
module wdt_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PRE_W  = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PRE_W-1:0]  prescale,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_timeout,
  input  logic [CNT_W-1:0]  cfg_window,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] kick,
  output logic [NUM_CH-1:0] wto,
  output logic [NUM_CH-1:0] early,
  output logic              irq,
  output logic [CNT_W-1:0]  rd_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] EXP  = 2'd2;

  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [CNT_W-1:0]  tmo_q [NUM_CH];
  logic [CNT_W-1:0]  win_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [1:0]        st_q  [NUM_CH];
  logic [NUM_CH-1:0] early_q;

  assign tick = (pre_cnt == prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Out-of-range cfg_ch matches no channel, so the write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tmo_q[i] <= '0;
        win_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          tmo_q[i] <= cfg_timeout;
          win_q[i] <= cfg_window;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        st_q[i]  <= IDLE;
      end
      early_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        case (st_q[i])
          IDLE: begin
            if (en[i]) begin
              st_q[i]  <= RUN;
              cnt_q[i] <= tmo_q[i];
            end
          end
          RUN: begin
            if (!en[i]) begin
              st_q[i] <= IDLE;
            end else if (kick[i]) begin
              // Kick beats a coincident zero tick.
              if ((win_q[i] != '0) && (cnt_q[i] > win_q[i])) begin
                st_q[i]    <= EXP;
                early_q[i] <= 1'b1;
              end else begin
                cnt_q[i] <= tmo_q[i];
              end
            end else if (tick) begin
              if (cnt_q[i] == '0) begin
                st_q[i] <= EXP;
              end else begin
                cnt_q[i] <= cnt_q[i] - 1'b1;
              end
            end
          end
          EXP: begin
            if (!en[i]) begin
              st_q[i]    <= IDLE;
              early_q[i] <= 1'b0;
            end
          end
          default: begin
            st_q[i]    <= IDLE;
            early_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    wto    = '0;
    rd_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wto[i] = (st_q[i] == EXP);
      if (cfg_ch == CH_W'(i)) begin
        rd_cnt = cnt_q[i];
      end
    end
  end

  assign early = early_q;
  assign irq   = |wto;

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi; three channels so that
// cfg_ch == NUM_CH is representable on the 2-bit select.
module tb_wdt_multi;

  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int PW  = 8;

  logic          clk;
  logic          rst;
  logic [PW-1:0] prescale;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_timeout;
  logic [CW-1:0] cfg_window;
  logic [NCH-1:0] en;
  logic [NCH-1:0] kick;
  logic [NCH-1:0] wto;
  logic [NCH-1:0] early;
  logic          irq;
  logic [CW-1:0] rd_cnt;

  int total = 0;
  int bad   = 0;

  wdt_multi #(
    .NUM_CH(NCH),
    .CNT_W (CW),
    .PRE_W (PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_timeout(cfg_timeout),
    .cfg_window (cfg_window),
    .en         (en),
    .kick       (kick),
    .wto        (wto),
    .early      (early),
    .irq        (irq),
    .rd_cnt     (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [CW-1:0] t,
                     input logic [CW-1:0] w);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_timeout = t;
    cfg_window  = w;
    step(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    prescale = '0;
    cfg_we = 1'b0;
    cfg_ch = '0;
    cfg_timeout = '0;
    cfg_window = '0;
    en = '0;
    kick = '0;
    #2;
    chk("rst_wto", wto, 0);
    chk("rst_early", early, 0);
    chk("rst_irq", irq, 0);
    chk("rst_cnt", rd_cnt, 0);
    step(2);
    rst = 1'b1;
    step(1);

    // P=0, ch0 T=3: cnt 3,2,1,0 then expiry on the 5th edge
    cfg(0, 3, 0);
    en[0] = 1'b1;
    step(1);
    chk("t1_cnt3", rd_cnt, 3);
    step(1);
    chk("t1_cnt2", rd_cnt, 2);
    step(1);
    chk("t1_cnt1", rd_cnt, 1);
    step(1);
    chk("t1_cnt0", rd_cnt, 0);
    chk("t1_nowto", wto, 0);
    step(1);
    chk("t1_wto", wto, 3'b001);
    chk("t1_irq", irq, 1);
    en[0] = 1'b0;
    step(1);
    chk("t1_clr", wto, 0);

    // P=3 with pre_cnt at 0: ticks land every 4th edge
    prescale = 8'd3;
    cfg(1, 2, 0);
    en[1] = 1'b1;
    step(1);
    chk("t2_cnt2", rd_cnt, 2);
    step(2);
    chk("t2_cnt1", rd_cnt, 1);
    step(4);
    chk("t2_cnt0", rd_cnt, 0);
    step(3);
    chk("t2_nowto", wto, 0);
    step(1);
    chk("t2_wto", wto, 3'b010);
    en[1] = 1'b0;
    prescale = 8'd0;
    step(1);
    chk("t2_clr", wto, 0);

    // window 4: kick at 7 is early, kick at 4 reloads
    cfg(0, 10, 4);
    en[0] = 1'b1;
    step(1);
    chk("t3_cnt10", rd_cnt, 10);
    step(3);
    chk("t3_cnt7", rd_cnt, 7);
    kick[0] = 1'b1;
    step(1);
    kick[0] = 1'b0;
    chk("t3_wto", wto, 3'b001);
    chk("t3_early", early, 3'b001);
    chk("t3_hold", rd_cnt, 7);
    en[0] = 1'b0;
    step(1);
    chk("t3_clrw", wto, 0);
    chk("t3_clre", early, 0);
    en[0] = 1'b1;
    step(7);
    chk("t3_cnt4", rd_cnt, 4);
    kick[0] = 1'b1;
    step(1);
    kick[0] = 1'b0;
    chk("t3_reload", rd_cnt, 10);
    chk("t3_okwto", wto, 0);
    chk("t3_okearly", early, 0);

    // kick on the zero tick reloads instead of expiring
    en[0] = 1'b0;
    step(1);
    cfg(0, 2, 0);
    en[0] = 1'b1;
    step(3);
    chk("t4_cnt0", rd_cnt, 0);
    kick[0] = 1'b1;
    step(1);
    kick[0] = 1'b0;
    chk("t4_reload", rd_cnt, 2);
    chk("t4_nowto", wto, 0);
    en[0] = 1'b0;
    step(1);
    en[0] = 1'b1;
    kick[0] = 1'b1;
    step(1);
    kick[0] = 1'b0;
    chk("t4_enkick", rd_cnt, 2);
    chk("t4_enkick_e", early, 0);

    // T=0 expires on the first tick after enable
    en[0] = 1'b0;
    step(1);
    cfg(0, 0, 0);
    en[0] = 1'b1;
    step(1);
    chk("t5_run", wto, 0);
    step(1);
    chk("t5_wto", wto, 3'b001);
    en[0] = 1'b0;
    step(1);

    // sticky expiry on ch2, kicks ignored, new timeout on re-enable
    cfg(2, 5, 2);
    cfg_ch = 2'd2;
    en[2] = 1'b1;
    step(1);
    chk("t6_cnt5", rd_cnt, 5);
    kick[2] = 1'b1;
    step(1);
    chk("t6_wto", wto, 3'b100);
    chk("t6_early", early, 3'b100);
    step(2);
    kick[2] = 1'b0;
    chk("t6_sticky", wto, 3'b100);
    chk("t6_stickye", early, 3'b100);
    cfg(2, 6, 0);
    cfg_ch = 2'd2;
    chk("t6_hold", rd_cnt, 5);
    chk("t6_still", wto, 3'b100);
    en[2] = 1'b0;
    step(1);
    chk("t6_clrw", wto, 0);
    chk("t6_clre", early, 0);
    en[2] = 1'b1;
    step(1);
    chk("t6_newt", rd_cnt, 6);

    // async reset mid-run
    cfg_ch = 2'd0;
    en = 3'b111;
    step(2);
    chk("t7_pre", irq, 1);
    rst = 1'b0;
    #2;
    chk("t7_wto", wto, 0);
    chk("t7_early", early, 0);
    chk("t7_irq", irq, 0);
    chk("t7_cnt", rd_cnt, 0);
    en = '0;
    step(1);
    rst = 1'b1;
    step(1);

    // out-of-range write is dropped
    cfg(2'd3, 9, 1);
    cfg_ch = 2'd3;
    chk("t8_rd", rd_cnt, 0);
    en = 3'b111;
    step(1);
    chk("t8_rd_run", rd_cnt, 0);
    for (int i = 0; i < NCH; i++) begin
      cfg_ch = 2'(i);
      #1;
      chk("t8_chan", rd_cnt, 0);
    end
    en = '0;
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
